// File: rtl/ntsc_composite_gen_if.sv
// ntsc_composite_gen_if: fixed-latency pixel fetch bus between the composite generator and its pixel source
interface ntsc_composite_gen_if;
  logic       pix_req;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic [7:0] luma_in;
  logic [7:0] u_in;
  logic [7:0] v_in;
  modport master (output pix_req, pix_x, pix_y, input luma_in, u_in, v_in);
  modport slave (input pix_req, pix_x, pix_y, output luma_in, u_in, v_in);
endinterface

// File: rtl/ntsc_composite_gen.sv
// ntsc_composite_gen: 4xfsc NTSC composite sample generator (sync, burst, Y/U/V active video)
// NTSC_TESTPATTERN_EN adds a test_pattern input that swaps fetched pixels for eight colour bars.
module ntsc_composite_gen #(
  parameter int DAC_W        = 12,
  parameter int H_TOTAL      = 910,
  parameter int H_SYNC       = 67,
  parameter int BURST_START  = 76,
  parameter int BURST_LEN    = 36,
  parameter int ACT_START    = 136,
  parameter int ACT_W        = 752,
  parameter int V_TOTAL      = 262,
  parameter int V_SYNC_START = 3,
  parameter int V_SYNC_LEN   = 3,
  parameter int V_ACT_START  = 20,
  parameter int V_ACT_LINES  = 240,
  parameter int LVL_SYNC     = 0,
  parameter int LVL_BLANK    = 1024,
  parameter int BURST_AMP    = 256,
  parameter int LUMA_SHIFT   = 3,
  parameter int CHROMA_SHIFT = 2
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             color_enable,
`ifdef NTSC_TESTPATTERN_EN
  input  logic             test_pattern,
`endif
  ntsc_composite_gen_if.master pix,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             frame_start,
  output logic [DAC_W-1:0] dac_out
);
  localparam int SW = DAC_W + 2;
  localparam logic [DAC_W-1:0] L_SYNC  = DAC_W'(LVL_SYNC);
  localparam logic [DAC_W-1:0] L_BLANK = DAC_W'(LVL_BLANK);
  localparam logic [DAC_W-1:0] L_HI    = DAC_W'(LVL_BLANK + BURST_AMP);
  localparam logic [DAC_W-1:0] L_LO    = DAC_W'(LVL_BLANK - BURST_AMP);
  typedef enum logic [1:0] {R_BLANK, R_SYNC, R_BURST, R_ACT} region_t;
  logic [9:0] h, x_q;
  logic [8:0] v, y_q;
  logic [1:0] phase, ph1;
  int hh, vv;
  logic vline, aline, hs1, vs1, fs1;
  region_t reg0, reg1;
  assign hh = int'(h);
  assign vv = int'(v);
  assign vline = vv >= V_SYNC_START && vv < V_SYNC_START + V_SYNC_LEN;
  assign aline = vv >= V_ACT_START && vv < V_ACT_START + V_ACT_LINES;
  assign reg0 = vline ? (hh < H_TOTAL - H_SYNC ? R_SYNC : R_BLANK) :
                hh < H_SYNC ? R_SYNC :
                (hh >= BURST_START && hh < BURST_START + BURST_LEN) ? R_BURST :
                (aline && hh >= ACT_START && hh < ACT_START + ACT_W) ? R_ACT : R_BLANK;
  // Pixel coordinates are live during a request and hold the last fetched position otherwise
  assign pix.pix_req = reg0 == R_ACT;
  assign pix.pix_x = pix.pix_req ? 10'(hh - ACT_START) : x_q;
  assign pix.pix_y = pix.pix_req ? 9'(vv - V_ACT_START) : y_q;
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      h     <= '0;
      v     <= '0;
      phase <= '0;
      x_q   <= '0;
      y_q   <= '0;
      reg1  <= R_BLANK;
      ph1   <= '0;
      hs1   <= 1'b1;
      vs1   <= 1'b1;
      fs1   <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      h     <= hh == H_TOTAL - 1 ? '0 : h + 10'd1;
      if (hh == H_TOTAL - 1) v <= vv == V_TOTAL - 1 ? '0 : v + 9'd1;
      x_q   <= pix.pix_x;
      y_q   <= pix.pix_y;
      reg1  <= reg0;
      ph1   <= phase;
      hs1   <= !(hh < H_SYNC);
      vs1   <= !vline;
      fs1   <= h == '0 && v == '0;
    end
  logic [7:0] y_s;
  logic signed [7:0] u_s, v_s, cw;
`ifdef NTSC_TESTPATTERN_EN
  localparam logic [7:0] BAR_Y [8] = '{8'd235, 8'd210, 8'd170, 8'd145, 8'd106, 8'd81, 8'd41, 8'd16};
  localparam logic [7:0] BAR_U [8] = '{8'h00, 8'h9C, 8'h1C, 8'hB8, 8'h48, 8'hE4, 8'h64, 8'h00};
  localparam logic [7:0] BAR_V [8] = '{8'h00, 8'h12, 8'h9C, 8'hA6, 8'h5A, 8'h64, 8'hEE, 8'h00};
  logic [2:0] bar;
  // x_q holds the column of the pixel now in stage 1
  assign bar = 3'(x_q / 10'(ACT_W / 8));
  assign y_s = test_pattern ? BAR_Y[bar] : pix.luma_in;
  assign u_s = test_pattern ? BAR_U[bar] : pix.u_in;
  assign v_s = test_pattern ? BAR_V[bar] : pix.v_in;
`else
  assign y_s = pix.luma_in;
  assign u_s = pix.u_in;
  assign v_s = pix.v_in;
`endif
  logic signed [SW-1:0] ce, c, ye, act;
  logic [DAC_W-1:0] sat, bst, nxt;
  assign cw  = ph1[0] ? v_s : u_s;
  assign ce  = SW'(cw);
  assign c   = color_enable ? (ph1[1] ? -ce : ce) <<< CHROMA_SHIFT : '0;
  assign ye  = signed'(SW'(y_s)) <<< LUMA_SHIFT;
  assign act = SW'(LVL_BLANK) + ye + c;
  assign sat = act[SW-1] ? '0 : |act[SW-2:DAC_W] ? '1 : act[DAC_W-1:0];
  assign bst = (!color_enable || !ph1[0]) ? L_BLANK : ph1[1] ? L_HI : L_LO;
  assign nxt = reg1 == R_SYNC ? L_SYNC : reg1 == R_BURST ? bst : reg1 == R_ACT ? sat : L_BLANK;
  always_ff @(posedge clk or posedge RESET)
    if (RESET) begin
      dac_out     <= L_BLANK;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      dac_out     <= nxt;
      hsync_n     <= hs1;
      vsync_n     <= vs1;
      frame_start <= fs1;
    end
endmodule

// File: tb/tb_ntsc_composite_gen.sv
// tb_ntsc_composite_gen: directed scoreboard bench; expected samples keyed on raster position k = v*910 + h
module tb_ntsc_composite_gen;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic color_enable = 1'b1;
`ifdef NTSC_TESTPATTERN_EN
  logic test_pattern = 1'b0;
`endif
  logic hsync_n, vsync_n, frame_start;
  logic [11:0] dac_out;
  ntsc_composite_gen_if pix();
  ntsc_composite_gen dut (
    .clk(clk), .RESET(RESET), .color_enable(color_enable),
`ifdef NTSC_TESTPATTERN_EN
    .test_pattern(test_pattern),
`endif
    .pix(pix), .hsync_n(hsync_n), .vsync_n(vsync_n), .frame_start(frame_start), .dac_out(dac_out)
  );
  always #5 clk = ~clk;
  typedef struct {int k; int sig; int val; string nm;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, ph = 0;
  int dac0 = 0, hs0 = 0, vsl = 0, fsc = 0, re = 0, r20 = 0, r21 = 0;
  int xf = -1, xl = -1, y20 = -1, y21 = -1, hold_x = -1;
  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask
  task automatic push(input int k, input int sig, input int val, input string nm);
    q.push_back('{k, sig, val, nm});
  endtask
  function automatic int sig_val(input int s);
    return s == 0 ? int'(dac_out) : s == 1 ? int'(hsync_n) : s == 2 ? int'(vsync_n) : int'(frame_start);
  endfunction
  always @(posedge clk or posedge RESET)
    if (RESET) cyc <= 0;
    else cyc <= cyc + 1;
  // Pixel source: answers a request one clock later
  always begin : src
    logic r;
    logic [9:0] x;
    @(negedge clk);
    r = pix.pix_req;
    x = pix.pix_x;
    @(posedge clk);
    #1;
    {pix.luma_in, pix.u_in, pix.v_in} = 24'h320000;
    if (r)
      case (x)
        10'd0:   {pix.luma_in, pix.u_in, pix.v_in} = {8'd255, 8'h00, 8'h00};
        10'd1:   {pix.luma_in, pix.u_in, pix.v_in} = {8'd0,   8'h00, 8'h00};
        10'd4:   {pix.luma_in, pix.u_in, pix.v_in} = {8'd255, 8'h7F, 8'h00};
        10'd8:   {pix.luma_in, pix.u_in, pix.v_in} = {8'd0,   8'h80, 8'h00};
        10'd9:   {pix.luma_in, pix.u_in, pix.v_in} = {8'd100, 8'h00, 8'd50};
        10'd10:  {pix.luma_in, pix.u_in, pix.v_in} = {8'd100, 8'd40, 8'h00};
        10'd11:  {pix.luma_in, pix.u_in, pix.v_in} = {8'd100, 8'h00, 8'hE2};
        10'd751: {pix.luma_in, pix.u_in, pix.v_in} = {8'd200, 8'h00, 8'h00};
        default: ;
      endcase
  end
  always @(negedge clk) begin
    color_enable = !(cyc / 910 == 2 || cyc / 910 == 21);
`ifdef NTSC_TESTPATTERN_EN
    test_pattern = cyc / 910 == 22;
`endif
  end
  always @(negedge clk) if (!RESET) begin : mon
    int pos, line;
    exp_t e;
    pos = cyc - 2;
    line = cyc / 910;
    while (q.size() > 0 && q[0].k <= pos) begin
      e = q.pop_front();
      chk(e.nm, e.k == pos ? sig_val(e.sig) : -1, e.val);
    end
    if (ph == 1) begin
      if (pos >= 0 && pos < 910 && dac_out == 12'd0) dac0++;
      if (pos >= 0 && pos < 910 && !hsync_n) hs0++;
      if (pos >= 0 && !vsync_n) vsl++;
      if (pos >= 0 && frame_start) fsc++;
      if (pix.pix_req) begin
        if (line < 20) re++;
        else if (line == 20) begin
          r20++;
          if (r20 == 1) xf = int'(pix.pix_x);
          xl = int'(pix.pix_x);
          y20 = int'(pix.pix_y);
        end else if (line == 21) begin
          r21++;
          y21 = int'(pix.pix_y);
        end
      end
      if (cyc == 20 * 910 + 900) hold_x = int'(pix.pix_x);
    end
  end
  initial begin
    {pix.luma_in, pix.u_in, pix.v_in} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dac", dac_out, 1024);
    chk("rst_hsync", hsync_n, 1);
    chk("rst_vsync", vsync_n, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_req", pix.pix_req, 0);
    chk("rst_x", pix.pix_x, 0);
    push(-1, 0, 1024, "pre_update");
    push(0, 0, 0, "sync_first"); push(0, 1, 0, "hs_first"); push(0, 2, 1, "vs_line0"); push(0, 3, 1, "fs_pulse");
    push(1, 3, 0, "fs_end");
    push(66, 0, 0, "sync_last"); push(66, 1, 0, "hs_last");
    push(67, 0, 1024, "blank_after_sync"); push(67, 1, 1, "hs_release");
    push(76, 0, 1024, "burst0_p0"); push(77, 0, 768, "burst0_p1");
    push(78, 0, 1024, "burst0_p2"); push(79, 0, 1280, "burst0_p3");
    push(111, 0, 1280, "burst0_end"); push(112, 0, 1024, "burst0_after");
    push(986, 0, 1024, "burst1_p2"); push(987, 0, 1280, "burst1_p3");
    push(988, 0, 1024, "burst1_p0"); push(989, 0, 768, "burst1_p1");
    push(1897, 0, 1024, "burst_off_a"); push(1899, 0, 1024, "burst_off_b");
    push(2729, 2, 1, "vs_before");
    push(2730, 0, 0, "vsync_sync"); push(2730, 2, 0, "vs_start");
    push(3572, 0, 0, "vsync_sync_end"); push(3573, 0, 1024, "vsync_blank");
    push(5459, 2, 0, "vs_last"); push(5460, 0, 0, "line6_sync"); push(5460, 2, 1, "vs_end");
    push(18335, 0, 1024, "pre_active");
    push(18336, 0, 3064, "y255"); push(18337, 0, 1024, "y0");
    push(18340, 0, 3572, "y255_u127"); push(18341, 0, 1424, "y50");
    push(18344, 0, 512, "y0_um128"); push(18345, 0, 2024, "ph1_v");
    push(18346, 0, 1664, "ph2_negu"); push(18347, 0, 1944, "ph3_negv");
    push(19087, 0, 2624, "last_pixel"); push(19088, 0, 1024, "post_active");
    push(19250, 0, 3064, "nocolor_u127"); push(19254, 0, 1024, "nocolor_um128");
    push(19255, 0, 1824, "nocolor_v50");
`ifdef NTSC_TESTPATTERN_EN
    push(20156, 0, 2904, "bar_white"); push(20907, 0, 1152, "bar_black");
`else
    push(20156, 0, 3064, "line22_first"); push(20907, 0, 2624, "line22_last");
`endif
    ph = 1;
    @(negedge clk);
    RESET = 1'b0;
    wait (cyc == 20950);
    @(negedge clk);
    ph = 0;
    chk("queue1_drained", q.size(), 0);
    chk("l0_sync_len", dac0, 67);
    chk("l0_hs_len", hs0, 67);
    chk("vs_len", vsl, 2730);
    chk("fs_count", fsc, 1);
    chk("req_early", re, 0);
    chk("req_l20", r20, 752);
    chk("req_l21", r21, 752);
    chk("x_first", xf, 0);
    chk("x_last", xl, 751);
    chk("y_l20", y20, 0);
    chk("y_l21", y21, 1);
    chk("x_hold", hold_x, 751);
    @(posedge clk);
    #3 RESET = 1'b1;
    #1;
    chk("mid_rst_dac", dac_out, 1024);
    chk("mid_rst_hs", hsync_n, 1);
    chk("mid_rst_vs", vsync_n, 1);
    chk("mid_rst_req", pix.pix_req, 0);
    chk("mid_rst_x", pix.pix_x, 0);
    chk("mid_rst_y", pix.pix_y, 0);
    push(-1, 0, 1024, "re_pre_update");
    push(0, 0, 0, "re_sync_first"); push(0, 3, 1, "re_fs");
    push(66, 0, 0, "re_sync_last"); push(67, 0, 1024, "re_blank");
    repeat (2) @(negedge clk);
    RESET = 1'b0;
    wait (cyc == 100);
    @(negedge clk);
    chk("queue2_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
